buffer_word_serializer: RTL



---
 rtl/buffer_word_serializer_pkg.sv | 18 +
 rtl/buffer_word_serializer.sv | 82 ++++++++
 2 files changed

// File: rtl/buffer_word_serializer_pkg.sv
// Shared types and defaults for the buffer word serializer.
// State encoding matches the BufferMemory side: IDLE=0, SHIFT=1.
package buffer_word_serializer_pkg;

  localparam int unsigned DefDataWidth = 40;
  localparam int unsigned DefByteWidth = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } ser_state_e;

  // Byte counter width; a single-byte word still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

endpackage

// File: rtl/buffer_word_serializer.sv
// Pops words from a first-word-fall-through buffer and streams them out as bytes,
// one byte per cycle with no bubbles between consecutive words.
module buffer_word_serializer
  import buffer_word_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned BYTE_WIDTH = DefByteWidth,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_empty,
  output logic                  buf_ready,
  output logic [BYTE_WIDTH-1:0] out_byte,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned NumBytes = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned CntW     = cnt_width(NumBytes);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_width_check
    $error("DATA_WIDTH must be an integer multiple of BYTE_WIDTH");
  end

  ser_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_word;
  logic [CntW-1:0]       r_cnt;

  logic                  w_valid;
  logic                  w_last;
  logic                  w_xfer;
  logic                  w_pop;
  logic [BYTE_WIDTH-1:0] w_byte;

  assign w_valid = (r_state == StShift);
  assign w_last  = w_valid && (r_cnt == LastCnt);
  assign w_xfer  = w_valid && out_ready;

  // out_ready -> buf_ready is deliberate: the next word loads on the last byte's edge.
  assign buf_ready = reset && ((r_state == StIdle) || (w_xfer && w_last));
  assign w_pop     = buf_ready && !in_empty;

  always_comb begin
    w_byte = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (r_cnt == CntW'(i)) begin
        w_byte = r_word[((MSB_FIRST != 0) ? (NumBytes - 1 - i) : i) * BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_cnt   <= '0;
    end else if (w_pop) begin
      r_state <= StShift;
      r_word  <= in_data;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_state <= StIdle;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Idle byte is forced to zero so a stale word never shows on the bus.
  assign out_byte  = w_valid ? w_byte : '0;
  assign out_valid = w_valid;
  assign out_last  = w_last;
  assign busy      = w_valid;

endmodule
